// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and response codes.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    RSP_OKAY    = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_TIMEOUT = 2'b11
  } apb_rsp_e;

  function automatic apb_rsp_e apb_rsp_code(input logic err, input logic timeout);
    if (timeout)  return RSP_TIMEOUT;
    else if (err) return RSP_SLVERR;
    else          return RSP_OKAY;
  endfunction

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: command/response handshake in, SETUP/ACCESS out,
// with a PREADY timeout so a hung slave cannot stall the command source.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  iPCLK,
  input  logic                  iPRESETn,
  input  logic                  iCMD_VALID,
  output logic                  oCMD_READY,
  input  logic                  iCMD_WRITE,
  input  logic [ADDR_W-1:0]     iCMD_ADDR,
  input  logic [DATA_W-1:0]     iCMD_WDATA,
  input  logic [DATA_W/8-1:0]   iCMD_STRB,
  output logic                  oRSP_VALID,
  input  logic                  iRSP_READY,
  output logic [DATA_W-1:0]     oRSP_RDATA,
  output logic                  oRSP_ERR,
  output logic                  oRSP_TIMEOUT,
  output logic                  oPSEL,
  output logic                  oPENABLE,
  output logic                  oPWRITE,
  output logic [DATA_W/8-1:0]   oPSTRB,
  output logic [ADDR_W-1:0]     oPADDR,
  output logic [DATA_W-1:0]     oPWDATA,
  input  logic [DATA_W-1:0]     iPRDATA,
  input  logic                  iPREADY,
  input  logic                  iPSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  apb_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_hit;

  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [DATA_W/8-1:0]   pstrb_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]     pwdata_q;

  // The counter freezes on the terminating ACCESS cycle, so it never wraps.
  always_comb begin
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
    cnt_d       = cnt_q;
    if (state_q == ACCESS && !iPREADY && !timeout_hit && TIMEOUT_CYC != 0) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == RESP && iRSP_READY) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pstrb_q       <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (iCMD_VALID && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= iCMD_WRITE;
            paddr_q     <= iCMD_ADDR;
            pwdata_q    <= iCMD_WRITE ? iCMD_WDATA : '0;
            pstrb_q     <= iCMD_WRITE ? iCMD_STRB : '0;
            state_q     <= SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (iPREADY || timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= (iPREADY && !pwrite_q) ? iPRDATA : '0;
            rsp_err_q     <= iPREADY ? iPSLVERR : 1'b1;
            rsp_timeout_q <= !iPREADY;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (iRSP_READY) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oCMD_READY   = cmd_ready_q;
  assign oRSP_VALID   = rsp_valid_q;
  assign oRSP_RDATA   = rsp_rdata_q;
  assign oRSP_ERR     = rsp_err_q;
  assign oRSP_TIMEOUT = rsp_timeout_q;
  assign oPSEL        = psel_q;
  assign oPENABLE     = penable_q;
  assign oPWRITE      = pwrite_q;
  assign oPSTRB       = pstrb_q;
  assign oPADDR       = paddr_q;
  assign oPWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: randomized commands against a transaction-level model.
module tb_apb_master;

  localparam int T = 4;

  logic        iPCLK = 1'b0;
  logic        iPRESETn;
  logic        iCMD_VALID, oCMD_READY, iCMD_WRITE;
  logic [15:0] iCMD_ADDR;
  logic [31:0] iCMD_WDATA;
  logic [3:0]  iCMD_STRB;
  logic        oRSP_VALID, iRSP_READY;
  logic [31:0] oRSP_RDATA;
  logic        oRSP_ERR, oRSP_TIMEOUT;
  logic        oPSEL, oPENABLE, oPWRITE;
  logic [3:0]  oPSTRB;
  logic [15:0] oPADDR;
  logic [31:0] oPWDATA, iPRDATA;
  logic        iPREADY, iPSLVERR;

  apb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .iPCLK(iPCLK), .iPRESETn(iPRESETn),
    .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_WRITE(iCMD_WRITE),
    .iCMD_ADDR(iCMD_ADDR), .iCMD_WDATA(iCMD_WDATA), .iCMD_STRB(iCMD_STRB),
    .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY), .oRSP_RDATA(oRSP_RDATA),
    .oRSP_ERR(oRSP_ERR), .oRSP_TIMEOUT(oRSP_TIMEOUT),
    .oPSEL(oPSEL), .oPENABLE(oPENABLE), .oPWRITE(oPWRITE), .oPSTRB(oPSTRB),
    .oPADDR(oPADDR), .oPWDATA(oPWDATA), .iPRDATA(iPRDATA), .iPREADY(iPREADY),
    .iPSLVERR(iPSLVERR)
  );

  always #5 iPCLK = ~iPCLK;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          w;        // PREADY-low cycles the slave inserts
    logic [31:0] rd;
    bit          e;
    logic [31:0] x_rdata;
    bit          x_err;
    bit          x_to;
    int          x_acc;    // expected number of ACCESS cycles
    int          acc_cyc;  // cycle in which the command was accepted
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bp_arm = 0;

  always @(posedge iPCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a slave that answers after w wait cycles completes
  // normally if that happens within T ACCESS cycles, otherwise the transfer times out.
  function automatic item_t model(input item_t it);
    item_t r = it;
    if (it.w < T) begin
      r.x_to = 0; r.x_err = it.e; r.x_rdata = it.wr ? 32'h0 : it.rd; r.x_acc = it.w + 1;
    end else begin
      r.x_to = 1; r.x_err = 1; r.x_rdata = 32'h0; r.x_acc = T;
    end
    return r;
  endfunction

  // Behavioural slave: PREADY after the planned number of wait cycles, junk otherwise.
  int s_cnt = 0;
  always @(negedge iPCLK) begin
    if (iPRESETn && oPSEL && oPENABLE && exp_q.size() > 0) begin
      if (s_cnt == exp_q[0].w) begin
        iPREADY = 1'b1; iPRDATA = exp_q[0].rd; iPSLVERR = exp_q[0].e;
      end else begin
        iPREADY = 1'b0; iPRDATA = $urandom; iPSLVERR = 1'($urandom_range(0, 1));
      end
      s_cnt++;
    end else begin
      iPREADY = 1'b0; iPSLVERR = 1'b0; iPRDATA = $urandom; s_cnt = 0;
    end
  end

  // Response consumer: random backpressure, or a forced 5-cycle stall when armed.
  int bp_seen = 0;
  int bp_left = 0;
  always @(negedge iPCLK) begin
    if (bp_arm != bp_seen) begin bp_seen = bp_arm; bp_left = 5; end
    if (bp_left > 0 && oRSP_VALID) begin
      iRSP_READY = 1'b0; bp_left--;
    end else begin
      iRSP_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks bus phases and responses against the head of the scoreboard.
  initial begin
    int m_acc = 0;
    bit rsp_seen = 0;
    bit pend = 0;
    int hs_cyc = 0;
    item_t cur;
    forever begin
      @(negedge iPCLK);
      #2;
      if (!iPRESETn) begin
        exp_q.delete(); m_acc = 0; rsp_seen = 0; pend = 0;
        continue;
      end
      if (oPSEL) begin
        chk("psel_with_cmd", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          chk("paddr", oPADDR, cur.addr);
          chk("pwrite", oPWRITE, cur.wr);
          chk("pwdata", oPWDATA, cur.wr ? cur.wdata : 32'h0);
          chk("pstrb", oPSTRB, cur.wr ? cur.strb : 4'h0);
          if (!oPENABLE) begin
            chk("setup_cycle", cyc, cur.acc_cyc + 1);
            if (pend) chk("b2b_setup_after_hs", cyc, hs_cyc + 2);
            pend = 0;
          end else begin
            m_acc++;
          end
        end
      end else begin
        chk("bus_idle", {oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB}, 0);
      end
      if (oRSP_VALID) begin
        chk("rsp_with_cmd", 64'(exp_q.size() != 0), 1);
        chk("cmd_ready_in_resp", oCMD_READY, 0);
        chk("psel_in_resp", {oPSEL, oPENABLE}, 0);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          if (!rsp_seen) begin
            chk("rsp_latency", cyc - cur.acc_cyc, 2 + cur.x_acc);
            chk("access_cycles", m_acc, cur.x_acc);
            rsp_seen = 1;
          end
          chk("rsp_rdata", oRSP_RDATA, cur.x_rdata);
          chk("rsp_err", oRSP_ERR, cur.x_err);
          chk("rsp_timeout", oRSP_TIMEOUT, cur.x_to);
          if (iRSP_READY) begin
            hs_cyc = cyc; pend = iCMD_VALID;
            void'(exp_q.pop_front());
            m_acc = 0; rsp_seen = 0;
          end
        end
      end else begin
        chk("rsp_idle", {oRSP_RDATA, oRSP_ERR, oRSP_TIMEOUT}, 0);
      end
    end
  end

  task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int w, input logic [31:0] rd, input bit e);
    item_t it;
    int n = 0;
    it.wr = wr; it.addr = a; it.wdata = d; it.strb = s; it.w = w; it.rd = rd; it.e = e;
    it = model(it);
    @(negedge iPCLK);
    iCMD_VALID = 1'b1; iCMD_WRITE = wr; iCMD_ADDR = a; iCMD_WDATA = d; iCMD_STRB = s;
    while (!oCMD_READY && n < 200) begin
      @(negedge iPCLK);
      n++;
    end
    chk("cmd_accept", oCMD_READY, 1);
    if (oCMD_READY) begin
      it.acc_cyc = cyc;
      exp_q.push_back(it);
      @(posedge iPCLK);
    end
    #1;
    iCMD_VALID = 1'b0; iCMD_WRITE = 1'($urandom_range(0, 1));
    iCMD_ADDR = 16'($urandom); iCMD_WDATA = $urandom; iCMD_STRB = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || oRSP_VALID) && n < 300) begin
      @(negedge iPCLK);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    iPRESETn = 1'b0; iCMD_VALID = 1'b0; iCMD_WRITE = 1'b0; iCMD_ADDR = '0;
    iCMD_WDATA = '0; iCMD_STRB = '0; iRSP_READY = 1'b0; iPREADY = 1'b0;
    iPSLVERR = 1'b0; iPRDATA = '0;
    #12;
    chk("reset_ctrl_outs", {oCMD_READY, oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT, oRSP_RDATA}, 0);
    chk("reset_bus_outs", {oPSEL, oPENABLE, oPWRITE, oPSTRB, oPADDR, oPWDATA}, 0);
    #11 iPRESETn = 1'b1;

    issue(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);          // write, zero wait
    drain();
    issue(0, 16'h0020, 32'h0, 4'h0, 3, 32'h12345678, 0);          // read, 3 waits (PREADY meets timeout edge)
    drain();
    issue(1, 16'h0FFC, 32'hCAFEF00D, 4'h3, 0, 32'h0, 1);          // slave error
    drain();
    issue(0, 16'h0100, 32'h0, 4'h0, 50, 32'hA5A5A5A5, 0);         // timeout
    drain();
    issue(1, 16'h0200, 32'h55AA55AA, 4'h0, 1, 32'h0, 0);          // zero strobe write
    drain();

    bp_arm++;                                                      // backpressure + back-to-back
    issue(0, 16'h0300, 32'h0, 4'h0, 0, 32'h0BADF00D, 0);
    issue(1, 16'h0304, 32'h01020304, 4'h9, 2, 32'h0, 0);
    drain();

    issue(0, 16'h0400, 32'h0, 4'h0, 3, 32'h77777777, 0);          // reset mid-ACCESS
    n = 0;
    while (!(oPSEL && oPENABLE) && n < 10) begin
      @(negedge iPCLK);
      n++;
    end
    chk("reached_access", {oPSEL, oPENABLE}, 2'b11);
    #3 iPRESETn = 1'b0;
    #1;
    chk("rst_async_ctrl", {oCMD_READY, oRSP_VALID, oRSP_ERR, oRSP_TIMEOUT, oRSP_RDATA}, 0);
    chk("rst_async_bus", {oPSEL, oPENABLE, oPWRITE, oPSTRB, oPADDR, oPWDATA}, 0);
    repeat (2) @(negedge iPCLK);
    #3 iPRESETn = 1'b1;
    n = 0;
    while (!oCMD_READY && n < 5) begin
      @(negedge iPCLK);
      n++;
    end
    chk("rst_cmd_ready", oCMD_READY, 1);
    issue(0, 16'h0404, 32'h0, 4'h0, 1, 32'h13579BDF, 0);
    drain();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) bp_arm++;
      issue(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
            int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(negedge iPCLK);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
